// File: rtl/pipe_fwd_chain.sv
// Parametrised post-decode pipeline register chain with stall/bubble/flush
// handling, operand forwarding lookup and load-use hazard detection.
module pipe_fwd_chain #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8,
  parameter int STAGES = 3,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [RA_W-1:0]            in_dst,
  input  logic                       in_wr,
  input  logic                       in_late,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W*(STAGES-1)-1:0] next_data,
  input  logic [STAGES-1:0]          stall_req,
  input  logic [STAGES-1:0]          flush,
  input  logic [RA_W-1:0]            q_a,
  input  logic [RA_W-1:0]            q_b,
  output logic [STAGES-1:0]          st_valid,
  output logic [CTRL_W*STAGES-1:0]   st_ctrl,
  output logic [RA_W*STAGES-1:0]     st_dst,
  output logic [DATA_W*STAGES-1:0]   st_data,
  output logic                       stall_up,
  output logic [SEL_W-1:0]           fwd_a_sel,
  output logic [SEL_W-1:0]           fwd_b_sel,
  output logic [DATA_W-1:0]          fwd_a_data,
  output logic [DATA_W-1:0]          fwd_b_data
);

  // A late (load) result becomes forwardable from this stage onwards.
  localparam int READY_STG = 2;

  // Pipeline registers, indexed by stage number (1 = oldest-after-decode E).
  logic              vld_p  [1:STAGES];
  logic [CTRL_W-1:0] ctrl_p [1:STAGES];
  logic [RA_W-1:0]   dst_p  [1:STAGES];
  logic              wr_p   [1:STAGES];
  logic              late_p [1:STAGES];
  logic [DATA_W-1:0] data_p [1:STAGES];

  // What each stage would capture if it advances this cycle.
  logic              src_vld  [1:STAGES];
  logic [CTRL_W-1:0] src_ctrl [1:STAGES];
  logic [RA_W-1:0]   src_dst  [1:STAGES];
  logic              src_wr   [1:STAGES];
  logic              src_late [1:STAGES];
  logic [DATA_W-1:0] src_data [1:STAGES];

  logic [STAGES:1]   hold;
  logic [STAGES:1]   bubble;

  // Lookup results per query port (0 = a, 1 = b).
  logic [RA_W-1:0]   qry  [2];
  logic [SEL_W-1:0]  sel  [2];
  logic [DATA_W-1:0] fdat [2];
  logic              haz  [2];

  assign qry[0] = q_a;
  assign qry[1] = q_b;

  // A stall at stage j freezes stage j and every younger stage below it.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      acc     = acc | (stall_req[k-1] & ~reset);
      hold[k] = acc;
    end
  end

  // Select the source of each stage: decode inputs for stage 1, the older
  // neighbour plus its computed result for the rest. Bubbles come from the
  // stage feeding this one being held (or decode being stalled).
  always_comb begin
    src_vld[1]  = in_valid;
    src_ctrl[1] = in_ctrl;
    src_dst[1]  = in_dst;
    src_wr[1]   = in_wr & in_valid;
    src_late[1] = in_late;
    src_data[1] = in_data;
    bubble[1]   = stall_up;
    for (int k = 2; k <= STAGES; k++) begin
      src_vld[k]  = vld_p[k-1];
      src_ctrl[k] = ctrl_p[k-1];
      src_dst[k]  = dst_p[k-1];
      src_wr[k]   = wr_p[k-1];
      src_late[k] = late_p[k-1];
      src_data[k] = next_data[(k-2)*DATA_W +: DATA_W];
      bubble[k]   = hold[k-1];
    end
  end

  // ---- stage register update: reset > flush > hold > bubble > advance ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        vld_p[k]  <= 1'b0;
        ctrl_p[k] <= '0;
        dst_p[k]  <= '0;
        wr_p[k]   <= 1'b0;
        late_p[k] <= 1'b0;
        data_p[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (!hold[k]) begin
          ctrl_p[k] <= src_ctrl[k];
          dst_p[k]  <= src_dst[k];
          late_p[k] <= src_late[k];
          data_p[k] <= src_data[k];
          wr_p[k]   <= src_wr[k] & ~bubble[k];
        end
        if (flush[k-1]) begin
          vld_p[k] <= 1'b0;
        end else if (!hold[k]) begin
          vld_p[k] <= src_vld[k] & ~bubble[k];
        end
      end
    end
  end

  // Forwarding lookup: youngest matching writer wins; a late writer that is
  // not yet ready turns into a load-use hazard instead of a forward.
  always_comb begin
    logic found;
    for (int p = 0; p < 2; p++) begin
      sel[p]  = '0;
      fdat[p] = '0;
      haz[p]  = 1'b0;
      found   = 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        if (!found && vld_p[k] && wr_p[k] && (dst_p[k] == qry[p]) &&
            (qry[p] != '0)) begin
          found = 1'b1;
          if (late_p[k] && (k < READY_STG)) begin
            haz[p] = 1'b1;
          end else begin
            sel[p]  = SEL_W'(k);
            fdat[p] = data_p[k];
          end
        end
      end
    end
  end

  assign stall_up   = hold[1] | haz[0] | haz[1];
  assign fwd_a_sel  = sel[0];
  assign fwd_b_sel  = sel[1];
  assign fwd_a_data = fdat[0];
  assign fwd_b_data = fdat[1];

  // Flatten the stage registers onto the packed output buses.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      st_valid[k-1]                    = vld_p[k];
      st_ctrl[(k-1)*CTRL_W +: CTRL_W]  = ctrl_p[k];
      st_dst[(k-1)*RA_W +: RA_W]       = dst_p[k];
      st_data[(k-1)*DATA_W +: DATA_W]  = data_p[k];
    end
  end

endmodule
